// File: rtl/ahb_crypto_slave_if.sv
// AHB-Lite slave bus bundle for the crypto register block.
// Latency: n/a (wiring only).
// Backpressure: carried by HREADYOUT from slave, HREADY back into slave.
interface ahb_crypto_slave_if #(
  parameter int DATA_W = 64
);
  logic              HSEL;
  logic              HWRITE;
  logic              HREADY;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport master (
    output HSEL, HWRITE, HREADY, HADDR, HTRANS, HSIZE, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HWRITE, HREADY, HADDR, HTRANS, HSIZE, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_crypto_slave.sv
// AHB-Lite register front end for a crypto engine: CTRL, keys, DATA_IN/OUT, STATUS.
// Latency: zero-wait register access; DATA_OUT read while busy stalls until result or WAIT_MAX.
// Backpressure: HREADYOUT low in WAIT and first error cycle; errors use the two-cycle response.
module ahb_crypto_slave #(
  parameter int DATA_W    = 64,
  parameter int NUM_KEYS  = 3,
  parameter int REG_SHIFT = 10,
  parameter int WAIT_MAX  = 16
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  ahb_crypto_slave_if.slave          bus,
  output logic                       start,
  output logic                       mode,
  output logic [DATA_W-1:0]          data_in,
  output logic [NUM_KEYS*DATA_W-1:0] keys,
  input  logic                       result_valid,
  input  logic [DATA_W-1:0]          result_data
);

  localparam logic [3:0] R_CTRL  = 4'd0;
  localparam logic [3:0] R_DIN   = 4'(NUM_KEYS + 1);
  localparam logic [3:0] R_DOUT  = 4'(NUM_KEYS + 2);
  localparam logic [3:0] R_STAT  = 4'(NUM_KEYS + 3);
  localparam logic [2:0] SIZE_OK = (DATA_W == 64) ? 3'd3 : 3'd2;
  localparam logic [7:0] CNT_MAX = 8'(WAIT_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t                         state_q, state_d;
  logic                           aph_vld_q, aph_vld_d;
  logic                           aph_wr_q, aph_wr_d;
  logic [3:0]                     aph_reg_q, aph_reg_d;
  logic [7:0]                     cnt_q, cnt_d;
  logic                           start_q, start_d;
  logic                           mode_q, mode_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic [DATA_W-1:0]              din_q, din_d;
  logic [DATA_W-1:0]              dout_q, dout_d;
  logic [NUM_KEYS-1:0][DATA_W-1:0] key_q, key_d;

  logic [3:0] a_reg;
  logic       a_acc;
  logic       a_err;
  logic       a_wait;
  logic       dp_wr;
  logic       dp_rd;
  logic       din_wr;
  logic       hready_out;
  logic       hresp_out;
  logic [DATA_W-1:0] hrdata;
  logic       unused_bits;

  assign unused_bits = ^{bus.HADDR[31:REG_SHIFT+4], bus.HADDR[REG_SHIFT-1:0], bus.HTRANS[0]};

  // Address-phase decode; busy_d is used so a DATA_IN write completing this
  // cycle (or a result arriving) is already reflected in the busy check.
  always_comb begin
    a_reg  = bus.HADDR[REG_SHIFT+3:REG_SHIFT];
    a_acc  = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    a_err  = (a_reg > R_STAT) || (bus.HSIZE != SIZE_OK) ||
             (bus.HWRITE && ((a_reg == R_DOUT) || (a_reg == R_STAT))) ||
             (bus.HWRITE && busy_d && (a_reg <= R_DIN));
    a_wait = !bus.HWRITE && (a_reg == R_DOUT) && busy_d;
    dp_wr  = (state_q == ST_IDLE) && aph_vld_q && aph_wr_q;
    dp_rd  = (state_q == ST_IDLE) && aph_vld_q && !aph_wr_q;
    din_wr = dp_wr && (aph_reg_q == R_DIN);
  end

  // Register file next state: data-phase writes, engine handshake, done tracking.
  always_comb begin
    mode_d  = mode_q;
    din_d   = din_q;
    dout_d  = dout_q;
    key_d   = key_q;
    busy_d  = busy_q;
    done_d  = done_q;
    start_d = din_wr;
    if (dp_wr && (aph_reg_q == R_CTRL)) mode_d = bus.HWDATA[0];
    if (din_wr) begin
      din_d  = bus.HWDATA;
      busy_d = 1'b1;
    end
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (dp_wr && (aph_reg_q == 4'(k + 1))) key_d[k] = bus.HWDATA;
    end
    if (result_valid && busy_q) begin
      dout_d = result_data;
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    // A completed DATA_OUT read consumes the result, including one delivered from WAIT.
    if ((dp_rd && (aph_reg_q == R_DOUT)) || ((state_q == ST_WAIT) && result_valid)) done_d = 1'b0;
  end

  // Response FSM and address-phase capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    aph_vld_d  = aph_vld_q;
    aph_wr_d   = aph_wr_q;
    aph_reg_d  = aph_reg_q;
    hready_out = 1'b1;
    hresp_out  = 1'b0;
    if (bus.HREADY) begin
      aph_vld_d = a_acc;
      aph_wr_d  = bus.HWRITE;
      aph_reg_d = a_reg;
    end
    case (state_q)
      ST_WAIT: begin
        hready_out = result_valid;
        cnt_d      = cnt_q + 8'd1;
        if (result_valid)          state_d = ST_IDLE;
        else if (cnt_d == CNT_MAX) state_d = ST_ERR1;
      end
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp_out  = 1'b1;
        state_d    = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_out = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (a_acc && (state_d == ST_IDLE)) begin
      if (a_err) begin
        state_d = ST_ERR1;
      end else if (a_wait) begin
        state_d = ST_WAIT;
        cnt_d   = 8'd0;
      end
    end
  end

  // Read data mux: zero-wait register reads, or the engine result releasing a stall.
  always_comb begin
    hrdata = '0;
    if (dp_rd) begin
      if (aph_reg_q == R_CTRL) hrdata = {{(DATA_W-1){1'b0}}, mode_q};
      if (aph_reg_q == R_DIN)  hrdata = din_q;
      if (aph_reg_q == R_DOUT) hrdata = dout_q;
      if (aph_reg_q == R_STAT) hrdata = {{(DATA_W-2){1'b0}}, done_q, busy_q};
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (aph_reg_q == 4'(k + 1)) hrdata = key_q[k];
      end
    end else if ((state_q == ST_WAIT) && result_valid) begin
      hrdata = result_data;
    end
  end

  // State and register flops, all cleared by the asynchronous reset.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q   <= ST_IDLE;
      aph_vld_q <= 1'b0;
      aph_wr_q  <= 1'b0;
      aph_reg_q <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      din_q     <= '0;
      dout_q    <= '0;
      key_q     <= '0;
    end else begin
      state_q   <= state_d;
      aph_vld_q <= aph_vld_d;
      aph_wr_q  <= aph_wr_d;
      aph_reg_q <= aph_reg_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      key_q     <= key_d;
    end
  end

  assign bus.HREADYOUT = hready_out;
  assign bus.HRESP     = hresp_out;
  assign bus.HRDATA    = hrdata;
  assign start         = start_q;
  assign mode          = mode_q;
  assign data_in       = din_q;
  assign keys          = key_q;

endmodule

// File: tb/tb_ahb_crypto_slave.sv
// Directed bench for ahb_crypto_slave: register access, start/busy/done, wait and error responses, reset.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: HREADY is looped back from HREADYOUT (single-slave bus).
module tb_ahb_crypto_slave;

  localparam logic [31:0] A_CTRL = 32'h0000;
  localparam logic [31:0] A_KEY0 = 32'h0400;
  localparam logic [31:0] A_KEY1 = 32'h0800;
  localparam logic [31:0] A_KEY2 = 32'h0C00;
  localparam logic [31:0] A_DIN  = 32'h1000;
  localparam logic [31:0] A_DOUT = 32'h1400;
  localparam logic [31:0] A_STAT = 32'h1800;
  localparam logic [31:0] A_BAD  = 32'h1C00;

  logic         HCLK;
  logic         HRESET;
  logic         start;
  logic         mode;
  logic [63:0]  data_in;
  logic [191:0] keys;
  logic         result_valid;
  logic [63:0]  result_data;

  int vectors;
  int miscompares;

  logic [63:0] rd;
  int          nw;
  int          ne;
  logic        fr;

  ahb_crypto_slave_if #(.DATA_W(64)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_crypto_slave dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .bus          (bus),
    .start        (start),
    .mode         (mode),
    .data_in      (data_in),
    .keys         (keys),
    .result_valid (result_valid),
    .result_data  (result_data)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // One non-pipelined transfer; called 1ns after a posedge, returns 1ns after the posedge
  // following the completing data-phase cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [63:0] wd, output logic [63:0] rdat,
                      output int nwait, output int nerr, output logic fresp);
    bit fin;
    fin = 0; nwait = 0; nerr = 0; fresp = 1'b0; rdat = '0;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = wr; bus.HADDR = addr; bus.HSIZE = size;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = wd;
    for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
      @(negedge HCLK);
      if (bus.HREADYOUT) begin
        fin = 1; rdat = bus.HRDATA; fresp = bus.HRESP;
      end else if (bus.HRESP) nerr++;
      else nwait++;
      @(posedge HCLK); #1;
    end
    if (!fin) begin
      vectors++; miscompares++;
      $display("FAIL xfer_timeout addr=%h got no HREADYOUT, want one within 64 cycles", addr);
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b0; result_valid = 1'b0; result_data = '0;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HADDR = '0;
    bus.HSIZE = 3'd3; bus.HWDATA = '0;
    #12;
    vectors++;
    if ({bus.HREADYOUT, bus.HRESP, bus.HRDATA} !== {1'b1, 1'b0, 64'd0}) begin
      miscompares++;
      $display("FAIL reset_bus got rdy=%b resp=%b rdata=%h want 1 0 0", bus.HREADYOUT, bus.HRESP, bus.HRDATA);
    end
    vectors++;
    if ({start, mode, data_in, keys} !== '0) begin
      miscompares++;
      $display("FAIL reset_regs got start=%b mode=%b din=%h keys=%h want all 0", start, mode, data_in, keys);
    end
    @(negedge HCLK); HRESET = 1'b1;
    @(posedge HCLK); #1;
    xfer(1'b0, A_STAT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if ({rd, nw, ne, fr} !== {64'd0, 32'd0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_status got rd=%h nw=%0d ne=%0d resp=%b want 0 0 0 0", rd, nw, ne, fr);
    end
  endtask

  task automatic test_key_regs();
    logic [63:0] kv [3];
    logic [31:0] ka [3];
    kv[0] = 64'h0123456789ABCDEF; kv[1] = 64'h1111111111111111; kv[2] = 64'h2222222222222222;
    ka[0] = A_KEY0; ka[1] = A_KEY1; ka[2] = A_KEY2;
    for (int k = 0; k < 3; k++) begin
      xfer(1'b1, ka[k], 3'd3, kv[k], rd, nw, ne, fr);
      vectors++;
      if ({nw, ne, fr} !== {32'd0, 32'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL key%0d_write got nw=%0d ne=%0d resp=%b want 0 0 0", k, nw, ne, fr);
      end
    end
    for (int k = 0; k < 3; k++) begin
      xfer(1'b0, ka[k], 3'd3, '0, rd, nw, ne, fr);
      vectors++;
      if ({rd, nw, ne, fr} !== {kv[k], 32'd0, 32'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL key%0d_read got rd=%h nw=%0d ne=%0d resp=%b want %h 0 0 0", k, rd, nw, ne, fr, kv[k]);
      end
    end
    vectors++;
    if (keys !== {kv[2], kv[1], kv[0]}) begin
      miscompares++;
      $display("FAIL keys_port got %h want %h", keys, {kv[2], kv[1], kv[0]});
    end
  endtask

  task automatic test_start();
    xfer(1'b1, A_CTRL, 3'd3, 64'd1, rd, nw, ne, fr);
    xfer(1'b0, A_CTRL, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if ({rd, mode} !== {64'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL ctrl_read got rd=%h mode=%b want 1 1", rd, mode);
    end
    xfer(1'b1, A_DIN, 3'd3, 64'hA5A5A5A5A5A5A5A5, rd, nw, ne, fr);
    @(negedge HCLK);
    vectors++;
    if ({start, data_in, fr} !== {1'b1, 64'hA5A5A5A5A5A5A5A5, 1'b0}) begin
      miscompares++;
      $display("FAIL start_pulse got start=%b din=%h resp=%b want 1 a5a5a5a5a5a5a5a5 0", start, data_in, fr);
    end
    @(negedge HCLK);
    vectors++;
    if (start !== 1'b0) begin
      miscompares++;
      $display("FAIL start_width got start=%b on second cycle want 0", start);
    end
    @(posedge HCLK); #1;
    xfer(1'b0, A_STAT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if (rd !== 64'h1) begin
      miscompares++;
      $display("FAIL status_busy got %h want 1", rd);
    end
  endtask

  task automatic test_wait_result();
    fork
      xfer(1'b0, A_DOUT, 3'd3, '0, rd, nw, ne, fr);
      begin
        repeat (6) @(posedge HCLK);
        #1; result_valid = 1'b1; result_data = 64'hDEADBEEFCAFEF00D;
        @(posedge HCLK); #1; result_valid = 1'b0;
      end
    join
    vectors++;
    if ({rd, nw, ne, fr} !== {64'hDEADBEEFCAFEF00D, 32'd5, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL wait_result got rd=%h nw=%0d ne=%0d resp=%b want deadbeefcafef00d 5 0 0", rd, nw, ne, fr);
    end
    xfer(1'b0, A_STAT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if (rd !== 64'h0) begin
      miscompares++;
      $display("FAIL status_after_wait got %h want 0", rd);
    end
  endtask

  task automatic test_wait_timeout();
    xfer(1'b1, A_DIN, 3'd3, 64'h0F0F0F0F0F0F0F0F, rd, nw, ne, fr);
    xfer(1'b0, A_DOUT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if ({nw, ne, fr} !== {32'd16, 32'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL wait_timeout got nw=%0d ne=%0d resp=%b want 16 1 1", nw, ne, fr);
    end
    xfer(1'b0, A_STAT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if (rd !== 64'h1) begin
      miscompares++;
      $display("FAIL status_after_timeout got %h want 1", rd);
    end
    result_valid = 1'b1; result_data = 64'h123456789ABCDEF0;
    @(posedge HCLK); #1; result_valid = 1'b0;
    xfer(1'b0, A_STAT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if (rd !== 64'h2) begin
      miscompares++;
      $display("FAIL status_late_done got %h want 2", rd);
    end
    xfer(1'b0, A_DOUT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if ({rd, nw, ne, fr} !== {64'h123456789ABCDEF0, 32'd0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL dout_late got rd=%h nw=%0d ne=%0d resp=%b want 123456789abcdef0 0 0 0", rd, nw, ne, fr);
    end
    xfer(1'b0, A_STAT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if (rd !== 64'h0) begin
      miscompares++;
      $display("FAIL status_done_cleared got %h want 0", rd);
    end
    xfer(1'b0, A_DOUT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if ({rd, nw, ne, fr} !== {64'h123456789ABCDEF0, 32'd0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL dout_idle_reread got rd=%h nw=%0d ne=%0d resp=%b want 123456789abcdef0 0 0 0", rd, nw, ne, fr);
    end
  endtask

  task automatic test_errors();
    logic [31:0] ea [5];
    logic [2:0]  es [5];
    logic        ew [5];
    ea[0] = A_STAT; es[0] = 3'd3; ew[0] = 1'b1;
    ea[1] = A_DOUT; es[1] = 3'd3; ew[1] = 1'b1;
    ea[2] = A_KEY0; es[2] = 3'd2; ew[2] = 1'b1;
    ea[3] = A_BAD;  es[3] = 3'd3; ew[3] = 1'b0;
    ea[4] = A_KEY0; es[4] = 3'd2; ew[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      xfer(ew[i], ea[i], es[i], 64'hFFFFFFFFFFFFFFFF, rd, nw, ne, fr);
      vectors++;
      if ({nw, ne, fr} !== {32'd0, 32'd1, 1'b1}) begin
        miscompares++;
        $display("FAIL err_case%0d got nw=%0d ne=%0d resp=%b want 0 1 1", i, nw, ne, fr);
      end
    end
    xfer(1'b0, A_KEY0, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if (rd !== 64'h0123456789ABCDEF) begin
      miscompares++;
      $display("FAIL key0_after_err got %h want 0123456789abcdef", rd);
    end
    // Seen-but-idle transfer: no response, no register effect.
    bus.HSEL = 1'b1; bus.HTRANS = 2'b00; bus.HWRITE = 1'b1; bus.HADDR = A_STAT;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HWRITE = 1'b0;
    @(negedge HCLK);
    vectors++;
    if ({bus.HREADYOUT, bus.HRESP} !== 2'b10) begin
      miscompares++;
      $display("FAIL idle_trans got rdy=%b resp=%b want 1 0", bus.HREADYOUT, bus.HRESP);
    end
    @(posedge HCLK); #1;
    // Writes while busy.
    xfer(1'b1, A_DIN, 3'd3, 64'h5555555555555555, rd, nw, ne, fr);
    xfer(1'b1, A_CTRL, 3'd3, 64'd0, rd, nw, ne, fr);
    vectors++;
    if ({ne, fr, mode} !== {32'd1, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL ctrl_busy got ne=%0d resp=%b mode=%b want 1 1 1", ne, fr, mode);
    end
    xfer(1'b1, A_KEY1, 3'd3, 64'd0, rd, nw, ne, fr);
    vectors++;
    if ({ne, fr, keys[127:64]} !== {32'd1, 1'b1, 64'h1111111111111111}) begin
      miscompares++;
      $display("FAIL key1_busy got ne=%0d resp=%b key1=%h want 1 1 1111111111111111", ne, fr, keys[127:64]);
    end
    xfer(1'b1, A_DIN, 3'd3, 64'h9999999999999999, rd, nw, ne, fr);
    vectors++;
    if ({ne, fr, data_in} !== {32'd1, 1'b1, 64'h5555555555555555}) begin
      miscompares++;
      $display("FAIL din_busy got ne=%0d resp=%b din=%h want 1 1 5555555555555555", ne, fr, data_in);
    end
    // CTRL write errors while result arrives in its data phase; result still lands.
    fork
      xfer(1'b1, A_CTRL, 3'd3, 64'd0, rd, nw, ne, fr);
      begin
        @(posedge HCLK); #1; result_valid = 1'b1; result_data = 64'hFEEDFACE00000001;
        @(posedge HCLK); #1; result_valid = 1'b0;
      end
    join
    vectors++;
    if ({ne, fr, mode} !== {32'd1, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL ctrl_coincide got ne=%0d resp=%b mode=%b want 1 1 1", ne, fr, mode);
    end
    xfer(1'b0, A_STAT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if (rd !== 64'h2) begin
      miscompares++;
      $display("FAIL status_coincide got %h want 2", rd);
    end
    xfer(1'b0, A_DOUT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if (rd !== 64'hFEEDFACE00000001) begin
      miscompares++;
      $display("FAIL dout_coincide got %h want feedface00000001", rd);
    end
  endtask

  task automatic test_reset_mid_wait();
    xfer(1'b1, A_DIN, 3'd3, 64'h7777777777777777, rd, nw, ne, fr);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = A_DOUT; bus.HSIZE = 3'd3;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    vectors++;
    if ({bus.HREADYOUT, bus.HRESP} !== 2'b00) begin
      miscompares++;
      $display("FAIL in_wait got rdy=%b resp=%b want 0 0", bus.HREADYOUT, bus.HRESP);
    end
    #2; HRESET = 1'b0; #1;
    vectors++;
    if ({bus.HREADYOUT, bus.HRESP, bus.HRDATA} !== {1'b1, 1'b0, 64'd0}) begin
      miscompares++;
      $display("FAIL rst_wait_bus got rdy=%b resp=%b rdata=%h want 1 0 0", bus.HREADYOUT, bus.HRESP, bus.HRDATA);
    end
    vectors++;
    if ({start, mode, data_in, keys} !== '0) begin
      miscompares++;
      $display("FAIL rst_wait_regs got mode=%b din=%h keys=%h want all 0", mode, data_in, keys);
    end
    @(negedge HCLK); HRESET = 1'b1;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    vectors++;
    if (bus.HREADYOUT !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_release got rdy=%b want 1", bus.HREADYOUT);
    end
    @(posedge HCLK); #1;
    xfer(1'b0, A_STAT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if ({rd, nw, ne, fr} !== {64'd0, 32'd0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_status got rd=%h nw=%0d ne=%0d resp=%b want 0 0 0 0", rd, nw, ne, fr);
    end
    xfer(1'b0, A_DOUT, 3'd3, '0, rd, nw, ne, fr);
    vectors++;
    if ({rd, nw, ne, fr} !== {64'd0, 32'd0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_dout got rd=%h nw=%0d ne=%0d resp=%b want 0 0 0 0", rd, nw, ne, fr);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_key_regs();
    test_start();
    test_wait_result();
    test_wait_timeout();
    test_errors();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_crypto_slave.md
AHB_CRYPTO_SLAVE -- requirements
Module: ahb_crypto_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data bus and register width (32 or 64).
REQ-002 SHALL have parameter NUM_KEYS, default 3, number of key registers (1..6).
REQ-003 SHALL have parameter REG_SHIFT, default 10, log2 of the byte size of each register region.
REQ-004 SHALL have parameter WAIT_MAX, default 16, maximum wait states before a DATA_OUT read errors (1..255).
REQ-005 SHALL have port HCLK  input  1  clock.
REQ-006 SHALL have port HRESET  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports HSEL, HWRITE, HREADY  input  1 each  standard AHB-Lite slave select, direction and bus-ready.
REQ-008 SHALL have ports HADDR input 32, HTRANS input 2, HSIZE input 3, HWDATA input DATA_W  standard AHB-Lite address/data phase.
REQ-009 SHALL have ports HRDATA output DATA_W, HREADYOUT output 1, HRESP output 1  AHB-Lite read data and response.
REQ-010 SHALL have port start  output  1  one-cycle pulse launching the crypto engine.
REQ-011 SHALL have ports mode output 1 (CTRL bit0, 1=encrypt), data_in output DATA_W, keys output NUM_KEYS*DATA_W (key k at bits [k*DATA_W +: DATA_W]).
REQ-012 SHALL have ports result_valid input 1 (one-cycle pulse) and result_data input DATA_W  engine completion.

Function
REQ-013 SHALL decode region r = HADDR[REG_SHIFT+3:REG_SHIFT]: 0 CTRL, 1..NUM_KEYS KEY[r-1], NUM_KEYS+1 DATA_IN, NUM_KEYS+2 DATA_OUT (read-only), NUM_KEYS+3 STATUS (read-only); higher r is invalid.
REQ-014 SHALL register address phase (region, HWRITE, valid) only when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; IDLE/BUSY transfers get zero-wait OKAY.
REQ-015 SHALL flag error for: invalid region, HSIZE != log2(DATA_W/8), write to DATA_OUT or STATUS, write to DATA_IN or any KEY/CTRL while busy=1.
REQ-016 SHALL give errors the two-cycle response: cycle 1 HREADYOUT=0 HRESP=1, cycle 2 HREADYOUT=1 HRESP=1; an errored write SHALL leave all registers unchanged.
REQ-017 SHALL capture HWDATA into the addressed register in the data-phase cycle; registers read back on HRDATA with zero wait states (CTRL zero-extended).
REQ-018 SHALL, on a valid DATA_IN write, pulse start for exactly one cycle the cycle after the data phase and set busy=1.
REQ-019 SHALL, on result_valid, load DATA_OUT with result_data, clear busy, set done=1; result_valid while busy=0 SHALL be ignored.
REQ-020 SHALL clear done on a completed DATA_OUT read; STATUS reads {busy bit0, done bit1, zeros} without side effects.
REQ-021 SHALL implement FSM IDLE, WAIT, ERR1, ERR2: IDLE->ERR1 on error; IDLE->WAIT on DATA_OUT read with busy=1; WAIT->IDLE on result_valid (HREADYOUT=1, HRDATA=result_data that cycle); WAIT->ERR1 when wait counter reaches WAIT_MAX; ERR1->ERR2->IDLE unconditionally.
REQ-022 SHALL hold HREADYOUT=0, HRESP=0 in WAIT, counter 8-bit, cleared on WAIT entry, incremented per WAIT cycle.
REQ-023 SHALL, when WAIT times out, leave busy=1; a later result_valid still loads DATA_OUT and sets done.
REQ-024 SHALL, on DATA_OUT read with busy=0 and done=0, return the last DATA_OUT value with OKAY and zero wait.
REQ-025 SHALL, if DATA_IN write data phase and result_valid coincide, result is not possible (busy write errors); a CTRL write coinciding with result_valid while busy SHALL error and result SHALL still be captured.

Reset
REQ-026 SHALL on HRESET=0 asynchronously force: FSM IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, start=0, mode=0, busy=0, done=0, counter=0, data_in=0, DATA_OUT=0, all keys=0.
REQ-027 SHALL, on reset during WAIT or ERR1, abandon the transfer and resume with HREADYOUT=1 on first clock after release.

Verification
REQ-028 Write KEY0..KEY2=0x0123456789ABCDEF, 0x1111..., 0x2222..., read back each -> exact values, OKAY, zero waits.
REQ-029 Write CTRL=1, DATA_IN=0xA5A5A5A5A5A5A5A5 -> start pulses one cycle after data phase, mode=1, STATUS=0x1.
REQ-030 Read DATA_OUT while busy; result_valid after 5 cycles with 0xDEADBEEFCAFEF00D -> 5 wait states, HRDATA matches, STATUS then 0x0.
REQ-031 Read DATA_OUT while busy, no result_valid -> WAIT_MAX wait states then ERR1/ERR2 two-cycle ERROR; STATUS still 0x1.
REQ-032 Write STATUS region, HSIZE=2 access, region NUM_KEYS+4 -> each two-cycle ERROR, registers unchanged.
REQ-033 Assert HRESET=0 mid-WAIT -> HREADYOUT=1, HRESP=0, all registers 0 immediately.
